led_sched: RTL and testbench

LED_SCHED -- requirements
Module: led_sched

---
 rtl/led_sched.sv | 131 +++++++++++++
 tb/tb_led_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_sched.sv
// LED scheduler: free-running chase display, handed to one of two requesters
// for HOLD_TICKS display ticks under round-robin arbitration. Optional blink: LED_SCHED_BLINK_EN.
module led_sched #(
  parameter int unsigned CLK_DIV    = 10000000,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] req,
  input  logic [3:0] pat0,
  input  logic [3:0] pat1,
  output logic [1:0] gnt,
  output logic       done,
  output logic [3:0] led
);

  typedef enum logic {StChase, StHold} state_e;

  localparam logic [31:0] DivLast  = 32'(CLK_DIV - 1);
  localparam logic [7:0]  HoldLast = 8'(HOLD_TICKS - 1);

  state_e      state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        done_q, done_d;
  logic [3:0]  led_q, led_d;
  logic        tick;
  logic        win1;
`ifdef LED_SCHED_BLINK_EN
  logic [3:0]  pat_q, pat_d;
  logic        dark_q, dark_d;
`endif

  function automatic logic [3:0] chase_step(input logic [1:0] idx);
    logic [3:0] s;
    s      = 4'b1111;
    s[idx] = 1'b0;
    return s;
  endfunction

  assign tick = (div_q == DivLast);

  always_comb begin
    div_d   = tick ? 32'd0 : div_q + 32'd1;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = 1'b0;
    led_d   = led_q;
    // ptr_q holds the last released grant; 00 after reset so requester 0 wins a tie.
    win1    = (req == 2'b11) ? ptr_q[0] : req[1];
`ifdef LED_SCHED_BLINK_EN
    pat_d   = pat_q;
    dark_d  = dark_q;
`endif
    unique case (state_q)
      StChase: begin
        if (req != 2'b00) begin
          // A tick coinciding with a grant does not advance the chase.
          state_d = StHold;
          hcnt_d  = 8'd0;
          gnt_d   = win1 ? 2'b10 : 2'b01;
          led_d   = ~(win1 ? pat1 : pat0);
`ifdef LED_SCHED_BLINK_EN
          pat_d   = win1 ? pat1 : pat0;
          dark_d  = 1'b0;
`endif
        end else if (tick) begin
          led_d = chase_step(idx_q);
          idx_d = idx_q + 2'd1;
        end
      end
      StHold: begin
        if (((req & gnt_q) == 2'b00) || (tick && hcnt_q == HoldLast)) begin
          state_d = StChase;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
          ptr_d   = gnt_q;
          led_d   = chase_step(idx_q);
        end else if (tick) begin
          hcnt_d = hcnt_q + 8'd1;
`ifdef LED_SCHED_BLINK_EN
          dark_d = ~dark_q;
          led_d  = dark_q ? ~pat_q : 4'b1111;
`endif
        end
      end
      default: state_d = StChase;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StChase;
      div_q   <= 32'd0;
      hcnt_q  <= 8'd0;
      idx_q   <= 2'd0;
      ptr_q   <= 2'b00;
      gnt_q   <= 2'b00;
      done_q  <= 1'b0;
      led_q   <= 4'b1111;
`ifdef LED_SCHED_BLINK_EN
      pat_q   <= 4'd0;
      dark_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
`ifdef LED_SCHED_BLINK_EN
      pat_q   <= pat_d;
      dark_q  <= dark_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_sched.sv
// Directed bench for led_sched at CLK_DIV=4, HOLD_TICKS=3; ticks land every 4th edge after reset.
module tb_led_sched;
  logic       clk = 1'b0;
  logic       nrst;
  logic [1:0] req;
  logic [3:0] pat0, pat1;
  logic [1:0] gnt;
  logic       done;
  logic [3:0] led;
  int checks = 0;
  int errors = 0;

  led_sched #(.CLK_DIV(4), .HOLD_TICKS(3)) dut (
    .clk(clk), .nrst(nrst), .req(req), .pat0(pat0), .pat1(pat1),
    .gnt(gnt), .done(done), .led(led)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset for 3 edges; on return the next edge is edge 1 after release.
  task automatic do_reset(input logic [1:0] r, input logic [3:0] p0, input logic [3:0] p1);
    nrst = 1'b0; req = 2'b00; pat0 = p0; pat1 = p1;
    edges(3);
    nrst = 1'b1; req = r;
  endtask

  task automatic chase_seq(input string tag);
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    edges(3);
    checks++;
    if (led !== 4'b1111) begin errors++; $display("FAIL %s_pre_tick: got %b want 1111", tag, led); end
    for (int k = 0; k < 5; k++) begin
      edges(1);
      checks++;
      if (led !== exp_seq[k]) begin
        errors++; $display("FAIL %s_tick%0d: got %b want %b", tag, k + 1, led, exp_seq[k]);
      end
      if (k < 4) edges(3);
    end
  endtask

  task automatic test_reset;
    do_reset(2'b00, 4'd0, 4'd0);
    checks++;
    if ({gnt, done, led} !== 7'b00_0_1111) begin
      errors++; $display("FAIL reset_state: got gnt=%b done=%b led=%b want 00 0 1111", gnt, done, led);
    end
    chase_seq("chase");
  endtask

  task automatic test_hold;
    do_reset(2'b00, 4'b1010, 4'd0);
    edges(4);                       // tick 1 shows 1110, chase index now 1
    req = 2'b01;
    edges(1);                       // E5
    checks++;
    if ({gnt, done, led} !== 7'b01_0_0101) begin
      errors++; $display("FAIL hold_grant: got gnt=%b done=%b led=%b want 01 0 0101", gnt, done, led);
    end
    pat0 = 4'b0000;
    edges(10);                      // E15, two hold ticks seen
    checks++;
    if ({gnt, led} !== 6'b01_0101) begin
      errors++; $display("FAIL hold_steady: got gnt=%b led=%b want 01 0101", gnt, led);
    end
    edges(1);                       // E16, third hold tick ends grant
    checks++;
    if ({gnt, done} !== 3'b00_1) begin
      errors++; $display("FAIL hold_expire: got gnt=%b done=%b want 00 1", gnt, done);
    end
    req = 2'b00;
    edges(1);
    checks++;
    if ({gnt, done} !== 3'b00_0) begin
      errors++; $display("FAIL hold_done_pulse: got gnt=%b done=%b want 00 0", gnt, done);
    end
    edges(3);                       // E20
    checks++;
    if (led !== 4'b1101) begin errors++; $display("FAIL hold_resume1: got %b want 1101", led); end
    edges(4);                       // E24
    checks++;
    if (led !== 4'b1011) begin errors++; $display("FAIL hold_resume2: got %b want 1011", led); end
  endtask

  task automatic test_round_robin;
    do_reset(2'b11, 4'b0001, 4'b0010);
    edges(1);                       // E1
    checks++;
    if ({gnt, led} !== 6'b01_1110) begin
      errors++; $display("FAIL rr_first: got gnt=%b led=%b want 01 1110", gnt, led);
    end
    edges(11);                      // E12
    checks++;
    if ({gnt, done} !== 3'b00_1) begin
      errors++; $display("FAIL rr_gap1: got gnt=%b done=%b want 00 1", gnt, done);
    end
    edges(1);                       // E13
    checks++;
    if ({gnt, done, led} !== 7'b10_0_1101) begin
      errors++; $display("FAIL rr_second: got gnt=%b done=%b led=%b want 10 0 1101", gnt, done, led);
    end
    edges(11);                      // E24
    checks++;
    if ({gnt, done} !== 3'b00_1) begin
      errors++; $display("FAIL rr_gap2: got gnt=%b done=%b want 00 1", gnt, done);
    end
    edges(1);                       // E25
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rr_third: got %b want 01", gnt); end
    req = 2'b00;
  endtask

  task automatic test_drop;
    do_reset(2'b10, 4'd0, 4'b0110);
    edges(1);
    checks++;
    if ({gnt, led} !== 6'b10_1001) begin
      errors++; $display("FAIL drop_grant: got gnt=%b led=%b want 10 1001", gnt, led);
    end
    edges(3);                       // E4, one hold tick
    req = 2'b00;
    edges(1);
    checks++;
    if ({gnt, done, led} !== 7'b00_1_1110) begin
      errors++; $display("FAIL drop_release: got gnt=%b done=%b led=%b want 00 1 1110", gnt, done, led);
    end
    edges(1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL drop_done_clear: got %b want 0", done); end
  endtask

  task automatic test_reset_mid_hold;
    do_reset(2'b01, 4'b1010, 4'd0);
    edges(6);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rst_hold_pre: got %b want 01", gnt); end
    nrst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      edges(1);
      checks++;
      if ({gnt, done, led} !== 7'b00_0_1111) begin
        errors++; $display("FAIL rst_hold_abort%0d: got gnt=%b done=%b led=%b want 00 0 1111", k, gnt, done, led);
      end
    end
    req  = 2'b00;
    nrst = 1'b1;
    chase_seq("rst_chase");
  endtask

  task automatic test_blink;
    logic [3:0] exp_seq [3];
`ifdef LED_SCHED_BLINK_EN
    exp_seq = '{4'b1100, 4'b1111, 4'b1100};
`else
    exp_seq = '{4'b1100, 4'b1100, 4'b1100};
`endif
    do_reset(2'b01, 4'b0011, 4'd0);
    edges(1);                       // E1, grant
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (led !== exp_seq[k]) begin
        errors++; $display("FAIL blink%0d: got %b want %b", k, led, exp_seq[k]);
      end
      if (k == 0) edges(3); else edges(4);
    end
    checks++;                       // E12
    if ({gnt, done} !== 3'b00_1) begin
      errors++; $display("FAIL blink_end: got gnt=%b done=%b want 00 1", gnt, done);
    end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_round_robin();
    test_drop();
    test_reset_mid_hold();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
